// File: rtl/subword_lane_unit.sv
// Byte/halfword load-extract and store-merge lanes; registered outputs, 1-cycle latency, no back-pressure.
// SUBWORD_ALIGN_CHECK_EN adds a registered misalign flag for odd-address halfword accesses.
module subword_lane_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] word,
   input  logic [15:0] wdata,
   input  logic [1:0]  addr,
   input  logic        size,
   input  logic        sign,
   input  logic        write,
   output logic [31:0] result,
`ifdef SUBWORD_ALIGN_CHECK_EN
   output logic        misalign,
`endif
   output logic [3:0]  byte_en,
   output logic        out_valid
);

   logic [31:0] result_d, result_q;
   logic [3:0]  byte_en_d, byte_en_q;
   logic        out_valid_q;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[7:0];
      case (addr)
         2'd0: lane_b = word[7:0];
         2'd1: lane_b = word[15:8];
         2'd2: lane_b = word[23:16];
         2'd3: lane_b = word[31:24];
         default: lane_b = word[7:0];
      endcase
      lane_h = addr[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      result_d  = word;
      byte_en_d = 4'b0000;
      if (!write) begin
         if (size)
            result_d = {{16{sign & lane_h[15]}}, lane_h};
         else
            result_d = {{24{sign & lane_b[7]}}, lane_b};
      end else if (size) begin
         // addr[0] is deliberately ignored: halfword lanes are chosen by addr[1] only
         if (addr[1]) begin
            result_d[31:16] = wdata;
            byte_en_d       = 4'b1100;
         end else begin
            result_d[15:0]  = wdata;
            byte_en_d       = 4'b0011;
         end
      end else begin
         case (addr)
            2'd0: result_d[7:0]   = wdata[7:0];
            2'd1: result_d[15:8]  = wdata[7:0];
            2'd2: result_d[23:16] = wdata[7:0];
            2'd3: result_d[31:24] = wdata[7:0];
            default: result_d = word;
         endcase
         byte_en_d = 4'b0001 << addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q    <= 32'h0;
         byte_en_q   <= 4'b0000;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            result_q  <= result_d;
            byte_en_q <= byte_en_d;
         end
      end
   end

`ifdef SUBWORD_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         misalign_q <= 1'b0;
      else
         misalign_q <= in_valid & size & addr[0];
   end

   assign misalign = misalign_q;
`endif

   assign result    = result_q;
   assign byte_en   = byte_en_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_subword_lane_unit.sv
// Directed bench for subword_lane_unit with an expectation queue popped as each result emerges.
module tb_subword_lane_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] word;
   logic [15:0] wdata;
   logic [1:0]  addr;
   logic        size;
   logic        sign;
   logic        write;
   logic [31:0] result;
   logic [3:0]  byte_en;
   logic        out_valid;
`ifdef SUBWORD_ALIGN_CHECK_EN
   logic        misalign;
`endif

   subword_lane_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .word      (word),
      .wdata     (wdata),
      .addr      (addr),
      .size      (size),
      .sign      (sign),
      .write     (write),
      .result    (result),
`ifdef SUBWORD_ALIGN_CHECK_EN
      .misalign  (misalign),
`endif
      .byte_en   (byte_en),
      .out_valid (out_valid)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  be;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic        issued = 1'b0;
   logic [31:0] held_res = 32'h0;
   logic [3:0]  held_be  = 4'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Independent reference: shift-based extraction and mask-based merge.
   function automatic exp_t model(input logic [31:0] w, input logic [15:0] wd, input logic [1:0] a,
                                  input logic sz, input logic sg, input logic wr);
      exp_t        e;
      int          sh;
      logic [31:0] v, mask, rep;
      e.mis = sz & a[0];
      if (!wr) begin
         sh = (a[1] ? 16 : 0) + ((!sz && a[0]) ? 8 : 0);
         v  = w >> sh;
         if (sz) e.res = sg ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
         else    e.res = sg ? {{24{v[7]}}, v[7:0]}   : {24'h0, v[7:0]};
         e.be = 4'b0000;
      end else begin
         if (sz) begin
            mask = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            rep  = {wd, wd};
            e.be = a[1] ? 4'b1100 : 4'b0011;
         end else begin
            mask = 32'h0000_00FF << (8 * a);
            rep  = {4{wd[7:0]}};
            e.be = 4'b0001 << a;
         end
         e.res = (w & ~mask) | (rep & mask);
      end
      return e;
   endfunction

   task automatic drive(input logic [31:0] w, input logic [15:0] wd, input logic [1:0] a,
                        input logic sz, input logic sg, input logic wr);
      word = w; wdata = wd; addr = a; size = sz; sign = sg; write = wr;
      in_valid = 1'b1;
      issued   = 1'b1;
   endtask

   task automatic issue_exp(input logic [31:0] w, input logic [15:0] wd, input logic [1:0] a,
                            input logic sz, input logic sg, input logic wr,
                            input logic [31:0] xr, input logic [3:0] xb);
      exp_t e;
      e.res = xr; e.be = xb; e.mis = sz & a[0];
      sb.push_back(e);
      drive(w, wd, a, sz, sg, wr);
   endtask

   task automatic issue_mdl(input logic [31:0] w, input logic [15:0] wd, input logic [1:0] a,
                            input logic sz, input logic sg, input logic wr);
      sb.push_back(model(w, wd, a, sz, sg, wr));
      drive(w, wd, a, sz, sg, wr);
   endtask

   task automatic go_idle();
      in_valid = 1'b0;
      issued   = 1'b0;
   endtask

   // Advance one edge, then check whatever the previous cycle's inputs should have produced.
   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      chk({tag, "_vld"}, {31'h0, out_valid}, {31'h0, issued});
      if (issued) begin
         if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk({tag, "_res"}, result, e.res);
            chk({tag, "_be"}, {28'h0, byte_en}, {28'h0, e.be});
`ifdef SUBWORD_ALIGN_CHECK_EN
            chk({tag, "_mis"}, {31'h0, misalign}, {31'h0, e.mis});
`endif
            held_res = e.res;
            held_be  = e.be;
         end
      end else begin
         chk({tag, "_hold_res"}, result, held_res);
         chk({tag, "_hold_be"}, {28'h0, byte_en}, {28'h0, held_be});
`ifdef SUBWORD_ALIGN_CHECK_EN
         chk({tag, "_idle_mis"}, {31'h0, misalign}, 32'h0);
`endif
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; word = 32'h0; wdata = 16'h0;
      addr = 2'd0; size = 1'b0; sign = 1'b0; write = 1'b0;
      #1;
      chk("rst_res", result, 32'h0);
      chk("rst_be", {28'h0, byte_en}, 32'h0);
      chk("rst_vld", {31'h0, out_valid}, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      issue_exp(32'h887766F5, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF5, 4'b0000); tick("lb_s");
      issue_exp(32'h887766F5, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 32'h000000F5, 4'b0000); tick("lbu");
      issue_exp(32'h887766F5, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b0, 32'hFFFF8877, 4'b0000); tick("lh_s");
      issue_exp(32'h887766F5, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0, 32'h00008877, 4'b0000); tick("lhu");
      go_idle(); tick("idle1");
      issue_exp(32'h887766F5, 16'h00AB, 2'd2, 1'b0, 1'b0, 1'b1, 32'h88AB66F5, 4'b0100); tick("sb2");
      issue_exp(32'h887766F5, 16'h1234, 2'd0, 1'b1, 1'b0, 1'b1, 32'h88771234, 4'b0011); tick("sh0");
      issue_exp(32'h887766F5, 16'h1234, 2'd3, 1'b1, 1'b0, 1'b1, 32'h123466F5, 4'b1100); tick("sh3");
      go_idle(); tick("idle2");
      go_idle(); tick("idle3");

      // Signed byte loads on every lane, back to back.
      for (int i = 0; i < 4; i++) begin
         issue_mdl(32'h80FF7F01, 16'h0000, 2'(i), 1'b0, 1'b1, 1'b0);
         tick("sweep_lb");
      end
      // Byte stores on every lane with random data.
      for (int i = 0; i < 4; i++) begin
         issue_mdl($urandom, 16'($urandom), 2'(i), 1'b0, 1'($urandom), 1'b1);
         tick("sweep_sb");
      end
      for (int i = 0; i < 12; i++) begin
         issue_mdl($urandom, 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tick("rand");
      end

`ifdef SUBWORD_ALIGN_CHECK_EN
      issue_exp(32'h887766F5, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 32'h000066F5, 4'b0000); tick("lh_mis");
      issue_exp(32'h887766F5, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 32'h00000066, 4'b0000); tick("lb_a1");
`endif

      // Four-cycle byte-load stream, then reset lands mid-cycle with a request pending.
      for (int i = 0; i < 4; i++) begin
         issue_mdl(32'h887766F5, 16'h0000, 2'(i), 1'b0, 1'b0, 1'b0);
         tick("stream");
      end
      drive(32'hDEADBEEF, 16'h5555, 2'd1, 1'b0, 1'b0, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_vld", {31'h0, out_valid}, 32'h0);
      chk("arst_res", result, 32'h0);
      chk("arst_be", {28'h0, byte_en}, 32'h0);
      @(posedge clk); #1;
      chk("rst_hold_vld", {31'h0, out_valid}, 32'h0);
      chk("rst_hold_res", result, 32'h0);
      sb.delete();
      held_res = 32'h0;
      held_be  = 4'b0;
      go_idle();
      #2;
      reset = 1'b0;
      tick("post_rst");
      issue_exp(32'h11223344, 16'h00EE, 2'd3, 1'b0, 1'b0, 1'b1, 32'hEE223344, 4'b1000); tick("recover");
      go_idle(); tick("idle4");

      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
